// File: rtl/bsk_led_scheduler_pkg.sv
// Shared types and helpers for the BSK front-panel LED scheduler and other BSK arbiters.
package bsk_led_pkg;

    localparam int LED_WIDTH    = 16;
    localparam int LED_SLOT_LEN = 10;
    localparam int RR_MAX       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HOLD  = 2'd2
    } led_sched_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // Circular priority scan starting after 'last'; 'last' itself is tried last.
    function automatic rr_pick_t rr_next(input logic [RR_MAX-1:0] mask,
                                         input logic [2:0]        last,
                                         input int                n);
        rr_pick_t res;
        int       s;
        res = '0;
        for (int k = 1; k <= RR_MAX; k++) begin
            s = int'(last) + k;
            if (s >= n) s = s - n;
            if (k <= n && !res.valid && mask[s[2:0]]) begin
                res.valid = 1'b1;
                res.idx   = s[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bsk_rr_pick.sv
// Combinational round-robin picker: next enabled index after 'last', wrapping modulo N.
module bsk_rr_pick
    import bsk_led_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         mask_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [$clog2(N)-1:0] next_o,
    output logic                 valid_o
);

    localparam int SW = $clog2(N);

    logic [RR_MAX-1:0] mask_ext;
    logic [2:0]        last_ext;
    rr_pick_t          pick;

    always_comb begin
        mask_ext = RR_MAX'(mask_i);
        last_ext = 3'(last_i);
        pick     = rr_next(mask_ext, last_ext, N);
        next_o   = SW'(pick.idx);
        valid_o  = pick.valid;
    end

endmodule

// File: rtl/bsk_led_scheduler.sv
// Time-slot scheduler for the shared BSK front-panel LED bus: one SETUP cycle,
// then a HOLD phase with the owning latch enable raised, sources granted round-robin.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | no enabled source; bus and latch enables at zero
//  SETUP | first cycle of a slot (cnt=0); slot data on bus, enables low
//  HOLD  | cnt=1..SLOT_LEN-1; latch enable of the slot owner high
module bsk_led_scheduler
    import bsk_led_pkg::*;
#(
    parameter int N_SRC    = 4,
    parameter int WIDTH    = LED_WIDTH,
    parameter int SLOT_LEN = LED_SLOT_LEN
) (
    input  logic                     clk,
    input  logic                     iRst_n,
    input  logic [N_SRC*WIDTH-1:0]   iLed,
    input  logic [N_SRC-1:0]         iEn,
    input  logic                     iLampTest,
    output logic [WIDTH-1:0]         oLed,
    output logic [N_SRC-1:0]         oLe,
    output logic [$clog2(N_SRC)-1:0] oSel,
    output logic                     oRound,
    output logic                     oLampAct
);

    localparam int SW = $clog2(N_SRC);
    localparam int CW = $clog2(SLOT_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_LEN - 1);

    led_sched_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [SW-1:0]    last_q, last_d;
    logic             lamp_q, lamp_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [N_SRC-1:0] le_q, le_d;
    logic             round_q, round_d;
    logic             lamp_act_q, lamp_act_d;

    logic [SW-1:0]    nxt;
    logic             nxt_vld;
    logic             boundary;

    bsk_rr_pick #(.N(N_SRC)) u_pick (
        .mask_i  (iEn),
        .last_i  (last_q),
        .next_o  (nxt),
        .valid_o (nxt_vld)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        last_d     = last_q;
        lamp_d     = lamp_q;
        round_d    = 1'b0;
        led_d      = '0;
        le_d       = '0;
        lamp_act_d = 1'b0;

        boundary = (state_q == IDLE) || (state_q == HOLD && cnt_q == CNT_LAST);

        if (boundary) begin
            cnt_d = '0;
            if (nxt_vld) begin
                state_d = SETUP;
                sel_d   = nxt;
                last_d  = nxt;
                lamp_d  = iLampTest;
                round_d = (state_q == IDLE) || (nxt <= last_q);
            end else begin
                state_d = IDLE;
                lamp_d  = 1'b0;
            end
        end else if (state_q == SETUP) begin
            state_d = HOLD;
            cnt_d   = CW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Bus data follows the source with one edge of latency, even mid-HOLD.
        if (state_d != IDLE) begin
            led_d      = lamp_d ? '1 : iLed[int'(sel_d)*WIDTH +: WIDTH];
            lamp_act_d = lamp_d;
            if (state_d == HOLD) le_d = N_SRC'(1) << sel_d;
        end
    end

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            last_q     <= SW'(N_SRC - 1);
            lamp_q     <= 1'b0;
            led_q      <= '0;
            le_q       <= '0;
            round_q    <= 1'b0;
            lamp_act_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            lamp_q     <= lamp_d;
            led_q      <= led_d;
            le_q       <= le_d;
            round_q    <= round_d;
            lamp_act_q <= lamp_act_d;
        end
    end

    assign oLed     = led_q;
    assign oLe      = le_q;
    assign oSel     = sel_q;
    assign oRound   = round_q;
    assign oLampAct = lamp_act_q;

endmodule
